// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] data;
  } ps2_entry_t;

  // A frame is good when data plus parity hold an odd number of ones and the stop bit is high.
  function automatic logic ps2_frame_ok(input logic [7:0] d, input logic p, input logic stop);
    return (^{d, p}) & stop;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Circular first-word-fall-through FIFO; head is visible combinationally while not empty.
module sync_fifo_fwft #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 10,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_pop;
  logic             w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  // A pop on an empty FIFO is ignored; a push into a full FIFO only lands if a pop frees the slot.
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_count = r_count;
  // Empty FIFO presents zero rather than stale RAM contents.
  assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

  // Storage write; contents need no reset since reads are masked while empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronise pins, deframe, decode E0/F0 prefixes, queue scancodes.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int DECODE_PREFIX  = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ps2_clk,
  input  logic                            ps2_data,
  output logic                            rd_valid,
  input  logic                            rd_ready,
  output logic [7:0]                      rd_data,
  output logic                            rd_ext,
  output logic                            rd_brk,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
  output logic                            frame_err,
  output logic                            overflow,
  input  logic                            err_clr
);

  localparam int                WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   r_clk_hist;
  logic                   w_clk_s;
  logic                   w_dat_s;
  logic                   w_fall;

  ps2_state_t             r_state;
  logic [2:0]             r_idx;
  logic [7:0]             r_shift;
  logic                   r_par;
  logic [WD_W-1:0]        r_wdog;
  logic                   r_ext_pend;
  logic                   r_brk_pend;
  logic                   r_push;
  ps2_entry_t             r_entry;
  logic                   r_frame_err;
  logic                   r_overflow;

  logic                   w_good;
  logic                   w_bad;
  logic                   w_timeout;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_drop;
  ps2_entry_t             w_head;

  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
  assign w_dat_s = r_dat_sync[SYNC_STAGES-1];
  assign w_fall  = r_clk_hist & ~w_clk_s;

  // Pin synchronisers plus one history flop on the clock line for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_hist <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
      r_clk_hist <= w_clk_s;
    end
  end

  assign w_good    = ps2_frame_ok(r_shift, r_par, w_dat_s);
  assign w_bad     = w_fall && (r_state == STOP) && !w_good;
  // The watchdog fires on the edge where it would reach TIMEOUT_CYCLES; a sample edge rearms it instead.
  assign w_timeout = (r_state != IDLE) && !w_fall && (r_wdog == WD_LAST);

  // Deframer FSM with watchdog and prefix tracking; a good byte is handed to the FIFO one edge later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_wdog     <= '0;
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
      r_push     <= 1'b0;
    end else begin
      r_push <= 1'b0;
      if (r_state == IDLE || w_fall) r_wdog <= '0;
      else                           r_wdog <= r_wdog + WD_W'(1);

      if (w_timeout) begin
        r_state <= IDLE;
      end else if (w_fall) begin
        case (r_state)
          IDLE: begin
            if (!w_dat_s) begin
              r_state <= DATA;
              r_idx   <= '0;
            end
          end
          DATA: begin
            r_shift[r_idx] <= w_dat_s;
            r_idx          <= r_idx + 3'd1;
            if (r_idx == 3'd7) r_state <= PARITY;
          end
          PARITY: begin
            r_par   <= w_dat_s;
            r_state <= STOP;
          end
          STOP: begin
            r_state <= IDLE;
            if (w_good) begin
              if (DECODE_PREFIX != 0 && r_shift == PS2_EXT) begin
                r_ext_pend <= 1'b1;
              end else if (DECODE_PREFIX != 0 && r_shift == PS2_BRK) begin
                r_brk_pend <= 1'b1;
              end else begin
                r_push     <= 1'b1;
                r_entry    <= {r_ext_pend, r_brk_pend, r_shift};
                r_ext_pend <= 1'b0;
                r_brk_pend <= 1'b0;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // A push is lost only when the FIFO is full and the reader is not taking the head this cycle.
  assign w_drop = r_push && w_full && !rd_ready;

  // Sticky error flags; a fresh error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_frame_err <= (r_frame_err & ~err_clr) | w_bad | w_timeout;
      r_overflow  <= (r_overflow & ~err_clr) | w_drop;
    end
  end

  sync_fifo_fwft #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(ps2_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_push),
    .i_wdata (r_entry),
    .i_pop   (rd_ready),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (count)
  );

  assign rd_valid  = !w_empty;
  assign rd_data   = w_head.data;
  assign rd_ext    = w_head.ext;
  assign rd_brk    = w_head.brk;
  assign frame_err = r_frame_err;
  assign overflow  = r_overflow;

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 device-to-host receiver for the `puter` SoC keyboard path.
- Synchronises the PS/2 clock and data lines and deframes 11-bit frames: start, 8 data bits LSB-first, odd parity, stop.
- Optionally folds the `E0`/`F0` prefix bytes into extended/break flags.
- Queues results in a first-word-fall-through FIFO read with valid/ready.
- Sits between the board `ps2_clk`/`ps2_data` pins and the MMIO keyboard register.
- Adds frame-error detection, watchdog timeout, buffering, overflow reporting and prefix decoding.

## Interface
- `FIFO_DEPTH`, 8: entries, power of two, ≥2.
- `SYNC_STAGES`, 2: synchroniser flops per PS/2 line, ≥2.
- `TIMEOUT_CYCLES`, 5000: `clk` cycles without a PS/2 falling edge before an in-progress frame is aborted.
- `DECODE_PREFIX`, 1: 1 = fold `E0`/`F0` into flags; 0 = raw byte stream.
- `clk` in 1: system clock. One clock; reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `ps2_clk` in 1: asynchronous PS/2 clock pin.
- `ps2_data` in 1: asynchronous PS/2 data pin.
- `rd_valid` out 1: FIFO non-empty.
- `rd_ready` in 1: pop the head entry when `rd_valid`.
- `rd_data` out 8: head scancode.
- `rd_ext` out 1: head entry was preceded by `E0`.
- `rd_brk` out 1: head entry was preceded by `F0`.
- `count` out $clog2(FIFO_DEPTH+1): occupancy.
- `frame_err` out 1: sticky; bad parity, bad stop bit, or timeout.
- `overflow` out 1: sticky; a frame was dropped because the FIFO was full.
- `err_clr` in 1: one-cycle pulse that clears `frame_err` and `overflow`.

## Operation
- **Synchronisers.** Each pin passes through `SYNC_STAGES` flops, reset to 1.
  - A sample edge is a 1→0 transition of the synchronised clock, seen across one extra history flop.
- **Deframer FSM**, reset state IDLE. All transitions happen only on sample edges, except the timeout.
  - IDLE: data=0 → DATA with bit index 0. data=1 is a glitch; stay in IDLE, no error.
  - DATA: shift data into bit[index]. After index 7 → PARITY.
  - PARITY: capture the parity bit → STOP.
  - STOP: the frame is good if XOR(data bits, parity) = 1 and stop = 1. Either way → IDLE.
- **Bad frame:** set `frame_err` and discard the frame. Prefix state is unchanged.
- **Timeout:** in any state except IDLE, a watchdog counts `clk` cycles.
  - The watchdog resets to 0 on each sample edge.
  - On reaching `TIMEOUT_CYCLES`: set `frame_err`, discard the partial frame, → IDLE.
- **Prefix decode**, when `DECODE_PREFIX`=1:
  - A good `E0` sets `ext_pend`; a good `F0` sets `brk_pend`. Neither is pushed.
  - Any other good byte is pushed with `{ext_pend, brk_pend}`, then both are cleared.
  - With `DECODE_PREFIX`=0, every good byte is pushed with both flags at 0.
- **FIFO:** 10-bit entries, circular, read/write pointers of $clog2(FIFO_DEPTH) bits that wrap naturally.
  - Push when full and not popping in the same cycle: drop the entry, set `overflow`.
  - Push and pop together when full: both happen, `count` is unchanged.
  - Push and pop together when empty: push only; the pop is ignored because `rd_valid`=0.
  - `rd_ready` while empty: no effect.
- **Sticky flags:** `err_clr` clears them. A new error in the same cycle wins, so the flag stays set.
- **Reset** mid-frame or mid-prefix: FSM → IDLE, pending flags cleared, FIFO emptied, sticky flags cleared.
- **Reset values:** `rd_valid`=0, `rd_data`=0, `rd_ext`=0, `rd_brk`=0, `count`=0, `frame_err`=0, `overflow`=0.

## Timing
- Latency from a `ps2_clk` pin fall to its sample edge: `SYNC_STAGES`+1 `clk` edges.
- A good frame whose stop bit is sampled at edge E is written at edge E+1.
  - `rd_valid` and `count` update after edge E+1.
- FWFT: `rd_data`, `rd_ext` and `rd_brk` show the head combinationally from RAM at the read pointer.
  - Pop when `rd_valid`&&`rd_ready` at an edge; the next head is visible after that edge.
- `frame_err` sets at edge E for a bad stop or parity. For a timeout it sets at the edge where the counter reaches `TIMEOUT_CYCLES`.
- `ps2_clk` high and low phases must each last ≥ `SYNC_STAGES`+2 `clk` periods; shorter phases are undefined behaviour.

## Structure
- Shared package `ps2_pkg` holds:
  - the FSM state enum {IDLE, DATA, PARITY, STOP};
  - the constants `PS2_EXT`=8'hE0 and `PS2_BRK`=8'hF0;
  - the packed FIFO entry struct {ext, brk, data[7:0]}.
- One natural sub-module, `sync_fifo_fwft`: parameters depth and width, push/pop/full/empty/count.
- The synchronisers, edge detector, FSM, watchdog and prefix logic stay in the top module.

## Test plan
- Send `15` (parity 0, stop 1) with `rd_ready`=0 → `count`=1, `rd_data`=15, ext=0, brk=0, `frame_err`=0.
- Send `E0`,`F0`,`69` with `DECODE_PREFIX`=1 → exactly one entry: 69, ext=1, brk=1.
  - The same stimulus with `DECODE_PREFIX`=0 → three entries E0, F0, 69, all flags 0.
- Send `15` with parity=1 → no entry, `frame_err`=1. Pulse `err_clr` → 0.
  - Then send a good `1C` → entry 1C.
- Send start plus 4 data bits, then idle for `TIMEOUT_CYCLES`+10 → `frame_err`=1, FSM in IDLE.
  - A following good `2A` is received intact.
- Send `FIFO_DEPTH`+1 frames (01..09 for depth 8) with no pops → `count`=8, `overflow`=1.
  - Drain → 01..08 in order, `rd_valid`=0 afterwards.
  - Also push and pop in the same cycle while full → `count` stays 8.
- Assert `rst` after 5 bits of a frame → all outputs at their reset values.
  - The next full frame `15` is received correctly.
